// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage RV32I integer ALU with one output register stage.
// Decodes alu_op/func3/func7 into a 4-bit control code, evaluates the
// arithmetic, logic, shift or branch compare, and registers the outcome.
// Optional feature macro: ALU_OVF_FLAG_EN adds a registered signed-overflow
// flag (ovf) for ADD/SUB.
module ex_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [2:0]      alu_op,
    input  logic [2:0]      func3,
    input  logic            func7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_o,
    output logic            br_mark,
`ifdef ALU_OVF_FLAG_EN
    output logic            ovf,
`endif
    output logic [3:0]      alu_ctrl
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_BEQ  = 4'd10, ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12, ALU_BGE  = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15
    } alu_code_e;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_RTYPE  = 3'b010;
    localparam logic [2:0] OP_ITYPE  = 3'b011;

    alu_code_e       code;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] res_d;
    logic            br_d;

    logic            out_valid_q;
    logic [XLEN-1:0] alu_q;
    logic            br_q;
    logic [3:0]      ctrl_q;

    // Decode the instruction class and function fields into an ALU control code.
    always_comb begin
        // NOTE: default first so every path assigns code and no latch is inferred.
        code = ALU_ADD;
        case (alu_op)
            OP_BRANCH: begin
                case (func3)
                    3'b000:  code = ALU_BEQ;
                    3'b001:  code = ALU_BNE;
                    3'b100:  code = ALU_BLT;
                    3'b101:  code = ALU_BGE;
                    3'b110:  code = ALU_BLTU;
                    3'b111:  code = ALU_BGEU;
                    default: code = ALU_ADD;
                endcase
            end
            OP_RTYPE, OP_ITYPE: begin
                case (func3)
                    // Immediate forms have no SUB; bit 30 is part of the immediate.
                    3'b000:  code = (func7 && alu_op == OP_RTYPE) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = func7 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;

    // Evaluate the selected operation; branch codes produce only the compare bit.
    always_comb begin
        res_d = '0;
        br_d  = 1'b0;
        case (code)
            ALU_ADD:  res_d = sum;
            ALU_SUB:  res_d = diff;
            ALU_SLL:  res_d = op_a << shamt;
            ALU_SLT:  res_d = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: res_d = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  res_d = op_a ^ op_b;
            ALU_SRL:  res_d = op_a >> shamt;
            ALU_SRA:  res_d = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   res_d = op_a | op_b;
            ALU_AND:  res_d = op_a & op_b;
            ALU_BEQ:  br_d  = (op_a == op_b);
            ALU_BNE:  br_d  = (op_a != op_b);
            ALU_BLT:  br_d  = lt_s;
            ALU_BGE:  br_d  = !lt_s;
            ALU_BLTU: br_d  = lt_u;
            default:  br_d  = !lt_u;
        endcase
    end

    // Result register: capture on accepted input, flush wins over in_valid.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every output register is reset so outputs are defined before the first capture.
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            br_q        <= 1'b0;
            ctrl_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            out_valid_q <= in_valid && !flush;
            if (in_valid && !flush) begin
                alu_q  <= res_d;
                br_q   <= br_d;
                ctrl_q <= code;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign alu_o     = alu_q;
    assign br_mark   = br_q;
    assign alu_ctrl  = ctrl_q;

`ifdef ALU_OVF_FLAG_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        ovf_d = 1'b0;
        if (code == ALU_ADD)
            ovf_d = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
        else if (code == ALU_SUB)
            ovf_d = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
    end

    // Overflow flag register, captured alongside alu_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (in_valid && !flush)
            ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed, table-driven bench for ex_alu_unit, plus hand
// sequences for reset, flush and hold behaviour.
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [2:0]  alu_op;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic [31:0] alu_o;
    logic        br_mark;
    logic [3:0]  alu_ctrl;
`ifdef ALU_OVF_FLAG_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_alu_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .flush     (flush),
        .alu_op    (alu_op),
        .func3     (func3),
        .func7     (func7),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .alu_o     (alu_o),
        .br_mark   (br_mark),
`ifdef ALU_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .alu_ctrl  (alu_ctrl)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_br;
        logic [3:0]  exp_ctrl;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [2:0] op,
                         input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        flush    = f;
        alu_op   = op;
        func3    = f3;
        func7    = f7;
        op_a     = a;
        op_b     = b;
    endtask

    initial begin
        //            op      f3      f7    a             b             result        br    ctrl    ovf
        vecs[0]  = '{3'b000, 3'b000, 1'b0, 32'd3,        32'd4,        32'd7,        1'b0, 4'd0,  1'b0};
        vecs[1]  = '{3'b010, 3'b000, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 4'd1,  1'b0};
        vecs[2]  = '{3'b011, 3'b000, 1'b1, 32'd5,        32'd7,        32'd12,       1'b0, 4'd0,  1'b0};
        vecs[3]  = '{3'b010, 3'b001, 1'b0, 32'd1,        32'd33,       32'd2,        1'b0, 4'd2,  1'b0};
        vecs[4]  = '{3'b010, 3'b101, 1'b1, 32'h80000000, 32'd33,       32'hC0000000, 1'b0, 4'd7,  1'b0};
        vecs[5]  = '{3'b010, 3'b101, 1'b0, 32'h80000000, 32'd33,       32'h40000000, 1'b0, 4'd6,  1'b0};
        vecs[6]  = '{3'b011, 3'b101, 1'b1, 32'hF0000000, 32'd4,        32'hFF000000, 1'b0, 4'd7,  1'b0};
        vecs[7]  = '{3'b010, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 4'd3,  1'b0};
        vecs[8]  = '{3'b010, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 4'd4,  1'b0};
        vecs[9]  = '{3'b010, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 4'd5,  1'b0};
        vecs[10] = '{3'b010, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0, 4'd8,  1'b0};
        vecs[11] = '{3'b010, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 4'd9,  1'b0};
        vecs[12] = '{3'b001, 3'b000, 1'b0, 32'd5,        32'd5,        32'd0,        1'b1, 4'd10, 1'b0};
        vecs[13] = '{3'b001, 3'b001, 1'b0, 32'd5,        32'd5,        32'd0,        1'b0, 4'd11, 1'b0};
        vecs[14] = '{3'b001, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 4'd12, 1'b0};
        vecs[15] = '{3'b001, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 4'd13, 1'b0};
        vecs[16] = '{3'b001, 3'b110, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 4'd14, 1'b0};
        vecs[17] = '{3'b001, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 4'd15, 1'b0};
        vecs[18] = '{3'b001, 3'b010, 1'b0, 32'd2,        32'd3,        32'd5,        1'b0, 4'd0,  1'b0};
        vecs[19] = '{3'b100, 3'b111, 1'b1, 32'd2,        32'd3,        32'd5,        1'b0, 4'd0,  1'b0};
        vecs[20] = '{3'b000, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 4'd0,  1'b0};
        vecs[21] = '{3'b010, 3'b000, 1'b1, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 4'd1,  1'b0};
        vecs[22] = '{3'b000, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 4'd0,  1'b1};
        vecs[23] = '{3'b010, 3'b000, 1'b1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 4'd1,  1'b1};

        // Reset state before any clock edge.
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 32'd0);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset alu_o", alu_o, 32'd0);
        check("reset br_mark", {31'b0, br_mark}, 32'd0);
        check("reset alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors: one cycle latency each.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d alu_o", i), alu_o, vecs[i].exp_res);
            check($sformatf("vec%0d br_mark", i), {31'b0, br_mark}, {31'b0, vecs[i].exp_br});
            check($sformatf("vec%0d alu_ctrl", i), {28'b0, alu_ctrl}, {28'b0, vecs[i].exp_ctrl});
`ifdef ALU_OVF_FLAG_EN
            check($sformatf("vec%0d ovf", i), {31'b0, ovf}, {31'b0, vecs[i].exp_ovf});
`endif
        end

        // Capture a known value, then flush: out_valid drops and data holds.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'd100, 32'd23);
        @(posedge clk);
        #1;
        check("seed alu_o", alu_o, 32'd123);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b010, 3'b000, 1'b1, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush alu_o hold", alu_o, 32'd123);
        check("flush alu_ctrl hold", {28'b0, alu_ctrl}, 32'd0);

        // in_valid low: out_valid drops and data holds.
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 32'd9, 32'd9);
        @(posedge clk);
        #1;
        check("idle out_valid", {31'b0, out_valid}, 32'd0);
        check("idle alu_o hold", alu_o, 32'd123);
        check("idle br_mark hold", {31'b0, br_mark}, 32'd0);

        // Valid again after idle, a taken branch, then async reset mid-stream.
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b001, 3'b000, 1'b0, 32'd9, 32'd9);
        @(posedge clk);
        #1;
        check("resume out_valid", {31'b0, out_valid}, 32'd1);
        check("resume br_mark", {31'b0, br_mark}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst alu_o", alu_o, 32'd0);
        check("async rst br_mark", {31'b0, br_mark}, 32'd0);
        check("async rst alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b011, 3'b100, 1'b0, 32'h0000FFFF, 32'h00000F0F);
        @(posedge clk);
        #1;
        check("post rst xori", alu_o, 32'h0000F0F0);
        check("post rst out_valid", {31'b0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
